// File: rtl/id_ex_stage_pkg.sv
// Shared ID/EX pipeline definitions: forward-select encodings and control-bundle bit positions.
package id_ex_stage_pkg;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_sel_e;

    localparam int unsigned CTRL_MEM_READ = 0;
    localparam int unsigned CTRL_ALU_SRC  = 1;
    localparam int unsigned CTRL_USES_RS1 = 2;
    localparam int unsigned CTRL_USES_RS2 = 3;

endpackage

// File: rtl/id_ex_stage_operand_fwd_mux.sv
// Three-way operand forwarding select: register file, EX/MEM result or MEM/WB result.
module operand_fwd_mux
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [1:0]      sel,
    input  logic [XLEN-1:0] rf_data,
    input  logic [XLEN-1:0] exmem_data,
    input  logic [XLEN-1:0] memwb_data,
    output logic [XLEN-1:0] fwd_data
);

    // The reserved 2'b11 encoding falls through to the register-file value.
    always_comb begin
        fwd_data = rf_data;
        case (sel)
            FWD_EXMEM: fwd_data = exmem_data;
            FWD_MEMWB: fwd_data = memwb_data;
            default:   fwd_data = rf_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use bubble insertion and a saturating bubble counter.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CTRL_W     = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    output logic                  id_ready,
    input  logic [XLEN-1:0]       id_instr,
    input  logic [XLEN-1:0]       id_pc,
    input  logic [XLEN-1:0]       id_rs1_data,
    input  logic [XLEN-1:0]       id_rs2_data,
    input  logic [XLEN-1:0]       id_imm,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [CTRL_W-1:0]     id_ctrl,
    input  logic [1:0]            forward_a,
    input  logic [1:0]            forward_b,
    input  logic [XLEN-1:0]       exmem_result,
    input  logic [XLEN-1:0]       memwb_result,
    input  logic                  flush,
    input  logic                  ex_ready,
    output logic                  ex_valid,
    output logic [XLEN-1:0]       ex_instr,
    output logic [XLEN-1:0]       ex_pc,
    output logic [XLEN-1:0]       ex_op_a,
    output logic [XLEN-1:0]       ex_op_b,
    output logic [XLEN-1:0]       ex_store_data,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [CTRL_W-1:0]     ex_ctrl,
    output logic [CNT_W-1:0]      bubble_count
);

    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] op_b;
    logic            adv;
    logic            rs_match;
    logic            lu;

    operand_fwd_mux #(.XLEN(XLEN)) u_fwd_a (
        .sel        (forward_a),
        .rf_data    (id_rs1_data),
        .exmem_data (exmem_result),
        .memwb_data (memwb_result),
        .fwd_data   (fwd_a)
    );

    operand_fwd_mux #(.XLEN(XLEN)) u_fwd_b (
        .sel        (forward_b),
        .rf_data    (id_rs2_data),
        .exmem_data (exmem_result),
        .memwb_data (memwb_result),
        .fwd_data   (fwd_b)
    );

    always_comb begin
        op_b     = id_ctrl[CTRL_ALU_SRC] ? id_imm : fwd_b;
        adv      = !ex_valid || ex_ready;
        rs_match = (id_ctrl[CTRL_USES_RS1] && (id_rs1 == ex_rd)) ||
                   (id_ctrl[CTRL_USES_RS2] && (id_rs2 == ex_rd));
        lu       = ex_valid && ex_ctrl[CTRL_MEM_READ] && (ex_rd != '0) && rs_match;
        id_ready = flush || (adv && !lu);
    end

    // Flush beats the bubble, which beats a normal advance; a stalled slot holds everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid      <= 1'b0;
            ex_instr      <= '0;
            ex_pc         <= '0;
            ex_op_a       <= '0;
            ex_op_b       <= '0;
            ex_store_data <= '0;
            ex_rd         <= '0;
            ex_ctrl       <= '0;
            bubble_count  <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (adv && lu && id_valid) begin
            ex_valid <= 1'b0;
            if (bubble_count != '1) begin
                bubble_count <= bubble_count + CNT_W'(1);
            end
        end else if (adv) begin
            ex_valid <= id_valid;
            if (id_valid) begin
                ex_instr      <= id_instr;
                ex_pc         <= id_pc;
                ex_op_a       <= fwd_a;
                ex_op_b       <= op_b;
                ex_store_data <= fwd_b;
                ex_rd         <= id_rd;
                ex_ctrl       <= id_ctrl;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scenario-based bench for id_ex_stage with a transaction-level reference model of the EX slot.
module tb_id_ex_stage;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned RW    = 5;
    localparam int unsigned CW    = 8;
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam int unsigned MR = 0, AS = 1, U1 = 2, U2 = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            id_valid, id_ready, flush, ex_ready, ex_valid;
    logic [XLEN-1:0] id_instr, id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [RW-1:0]   id_rs1, id_rs2, id_rd, ex_rd;
    logic [CW-1:0]   id_ctrl, ex_ctrl;
    logic [1:0]      forward_a, forward_b;
    logic [XLEN-1:0] exmem_result, memwb_result;
    logic [XLEN-1:0] ex_instr, ex_pc, ex_op_a, ex_op_b, ex_store_data;
    logic [CNT_W-1:0] bubble_count;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .REG_ADDR_W(RW), .CTRL_W(CW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
        .id_instr(id_instr), .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_ctrl(id_ctrl),
        .forward_a(forward_a), .forward_b(forward_b), .exmem_result(exmem_result),
        .memwb_result(memwb_result), .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
        .ex_instr(ex_instr), .ex_pc(ex_pc), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .bubble_count(bubble_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: contents of the single EX slot plus the bubble tally.
    logic            m_valid;
    logic [XLEN-1:0] m_instr, m_pc, m_op_a, m_op_b, m_store;
    logic [RW-1:0]   m_rd;
    logic [CW-1:0]   m_ctrl;
    logic [CNT_W-1:0] m_cnt;

    function automatic logic [XLEN-1:0] pick(input logic [1:0] sel, input logic [XLEN-1:0] rf);
        if (sel == 2'b10) return exmem_result;
        if (sel == 2'b01) return memwb_result;
        return rf;
    endfunction

    function automatic logic model_ready();
        logic dep, hazard, slot_free;
        dep       = (id_ctrl[U1] && id_rs1 == m_rd) || (id_ctrl[U2] && id_rs2 == m_rd);
        hazard    = m_valid && m_ctrl[MR] && (m_rd != 0) && dep;
        slot_free = !m_valid || ex_ready;
        return flush || (slot_free && !hazard);
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_instr = '0; m_pc = '0; m_op_a = '0; m_op_b = '0;
        m_store = '0; m_rd = '0; m_ctrl = '0; m_cnt = '0;
    endtask

    task automatic tick();
        logic accepted, bubble, keep;
        @(posedge clk);
        accepted = id_valid && model_ready() && !flush;
        bubble   = id_valid && !flush && (!m_valid || ex_ready) && !model_ready();
        keep     = m_valid && !ex_ready && !flush;
        if (accepted) begin
            m_instr = id_instr;
            m_pc    = id_pc;
            m_op_a  = pick(forward_a, id_rs1_data);
            m_store = pick(forward_b, id_rs2_data);
            m_op_b  = id_ctrl[AS] ? id_imm : m_store;
            m_rd    = id_rd;
            m_ctrl  = id_ctrl;
        end
        m_valid = accepted || keep;
        if (bubble && m_cnt != CNT_MAX) m_cnt = m_cnt + 1'b1;
        #1;
    endtask

    task automatic idle_inputs();
        id_valid = 1'b0; id_instr = '0; id_pc = '0; id_rs1_data = '0; id_rs2_data = '0;
        id_imm = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_ctrl = '0;
        forward_a = 2'b00; forward_b = 2'b00; exmem_result = '0; memwb_result = '0;
        flush = 1'b0; ex_ready = 1'b1;
    endtask

    task automatic present(input logic [CW-1:0] ctrl, input logic [RW-1:0] rs1,
                           input logic [RW-1:0] rs2, input logic [RW-1:0] rd);
        id_valid = 1'b1; id_ctrl = ctrl; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_instr = $urandom; id_pc = $urandom; id_rs1_data = $urandom;
        id_rs2_data = $urandom; id_imm = $urandom;
        forward_a = 2'b00; forward_b = 2'b00;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        n_checks++;
        if (ex_valid !== 1'b0 || bubble_count !== '0) begin
            n_fail++; $display("FAIL reset_ctrl ex_valid=%b cnt=%h want 0 0", ex_valid, bubble_count);
        end
        n_checks++;
        if ({ex_instr, ex_pc, ex_op_a, ex_op_b, ex_store_data, ex_rd, ex_ctrl} !== '0) begin
            n_fail++; $display("FAIL reset_data got %h %h %h %h %h %h %h want all 0",
                               ex_instr, ex_pc, ex_op_a, ex_op_b, ex_store_data, ex_rd, ex_ctrl);
        end
        n_checks++;
        if (id_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_id_ready got %b want 1", id_ready);
        end
        model_reset();
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_forward_a();
        present(8'b0000_1100, 5'd3, 5'd4, 5'd9);
        forward_a = 2'b10; exmem_result = 32'h55; id_rs1_data = 32'h11; ex_ready = 1'b1;
        #1;
        n_checks++;
        if (id_ready !== 1'b1) begin
            n_fail++; $display("FAIL fwd_a_ready got %b want 1", id_ready);
        end
        tick();
        n_checks++;
        if (ex_valid !== 1'b1 || ex_op_a !== 32'h55) begin
            n_fail++; $display("FAIL fwd_a_op got valid=%b op_a=%h want 1 00000055", ex_valid, ex_op_a);
        end
        n_checks++;
        if (ex_rd !== 5'd9 || ex_pc !== m_pc || ex_instr !== m_instr) begin
            n_fail++; $display("FAIL fwd_a_fields got rd=%h pc=%h want %h %h", ex_rd, ex_pc, 5'd9, m_pc);
        end
    endtask

    task automatic test_alu_src();
        present(8'b0000_1010, 5'd1, 5'd2, 5'd10);
        forward_b = 2'b01; memwb_result = 32'h99; id_imm = 32'h7; id_rs2_data = 32'h22;
        tick();
        n_checks++;
        if (ex_op_b !== 32'h7 || ex_store_data !== 32'h99) begin
            n_fail++; $display("FAIL alu_src got op_b=%h store=%h want 7 99", ex_op_b, ex_store_data);
        end
        n_checks++;
        if (ex_ctrl !== 8'h0a) begin
            n_fail++; $display("FAIL alu_src_ctrl got %h want 0a", ex_ctrl);
        end
    endtask

    task automatic test_load_use();
        logic [CNT_W-1:0] exp_cnt;
        exp_cnt = m_cnt + 1'b1;
        present(8'b0000_0101, 5'd1, 5'd0, 5'd5);
        tick();
        present(8'b0000_0100, 5'd5, 5'd0, 5'd6);
        forward_a = 2'b01; memwb_result = 32'hABCD;
        #1;
        n_checks++;
        if (id_ready !== 1'b0) begin
            n_fail++; $display("FAIL lu_stall_ready got %b want 0", id_ready);
        end
        tick();
        n_checks++;
        if (ex_valid !== 1'b0 || bubble_count !== exp_cnt || ex_rd !== 5'd5) begin
            n_fail++; $display("FAIL lu_bubble got valid=%b cnt=%h rd=%h want 0 %h 05",
                               ex_valid, bubble_count, ex_rd, exp_cnt);
        end
        n_checks++;
        if (id_ready !== 1'b1) begin
            n_fail++; $display("FAIL lu_release_ready got %b want 1", id_ready);
        end
        tick();
        n_checks++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || ex_op_a !== 32'hABCD || bubble_count !== exp_cnt) begin
            n_fail++; $display("FAIL lu_dependent got valid=%b rd=%h op_a=%h cnt=%h want 1 06 0000abcd %h",
                               ex_valid, ex_rd, ex_op_a, bubble_count, exp_cnt);
        end
    endtask

    task automatic test_no_hazard();
        logic [CNT_W-1:0] cnt0;
        cnt0 = m_cnt;
        present(8'b0000_0101, 5'd1, 5'd0, 5'd0);
        tick();
        present(8'b0000_0100, 5'd0, 5'd0, 5'd6);
        #1;
        n_checks++;
        if (id_ready !== 1'b1) begin
            n_fail++; $display("FAIL nohaz_x0_ready got %b want 1", id_ready);
        end
        tick();
        n_checks++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || bubble_count !== cnt0) begin
            n_fail++; $display("FAIL nohaz_x0 got valid=%b rd=%h cnt=%h want 1 06 %h",
                               ex_valid, ex_rd, bubble_count, cnt0);
        end
        present(8'b0000_0101, 5'd1, 5'd0, 5'd5);
        tick();
        present(8'b0000_0000, 5'd5, 5'd5, 5'd7);
        #1;
        n_checks++;
        if (id_ready !== 1'b1) begin
            n_fail++; $display("FAIL nohaz_unused_ready got %b want 1", id_ready);
        end
        tick();
        n_checks++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd7 || bubble_count !== cnt0) begin
            n_fail++; $display("FAIL nohaz_unused got valid=%b rd=%h cnt=%h want 1 07 %h",
                               ex_valid, ex_rd, bubble_count, cnt0);
        end
    endtask

    task automatic test_stall_flush();
        logic [XLEN-1:0] h_instr, h_op_a, h_op_b, h_store;
        logic [RW-1:0]   h_rd;
        present(8'b0000_0011, 5'd1, 5'd2, 5'd3);
        ex_ready = 1'b1;
        tick();
        h_instr = m_instr; h_op_a = m_op_a; h_op_b = m_op_b; h_store = m_store; h_rd = m_rd;
        ex_ready = 1'b0;
        present(8'b0000_0000, 5'd4, 5'd5, 5'd6);
        for (int k = 0; k < 3; k++) begin
            flush = (k == 2);
            #1;
            n_checks++;
            if (id_ready !== (k == 2)) begin
                n_fail++; $display("FAIL stall_ready[%0d] got %b want %b", k, id_ready, (k == 2));
            end
            tick();
            if (k < 2) begin
                n_checks++;
                if (ex_valid !== 1'b1 || ex_instr !== h_instr || ex_op_a !== h_op_a ||
                    ex_op_b !== h_op_b || ex_store_data !== h_store || ex_rd !== h_rd) begin
                    n_fail++; $display("FAIL stall_hold[%0d] got instr=%h rd=%h valid=%b want %h %h 1",
                                       k, ex_instr, ex_rd, ex_valid, h_instr, h_rd);
                end
            end else begin
                n_checks++;
                if (ex_valid !== 1'b0) begin
                    n_fail++; $display("FAIL flush_valid got %b want 0", ex_valid);
                end
            end
        end
        flush = 1'b0;
        #1;
        n_checks++;
        if (id_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_ready got %b want 1", id_ready);
        end
    endtask

    task automatic test_saturation();
        ex_ready = 1'b1;
        for (int i = 0; i < (1 << CNT_W) + 4; i++) begin
            present(8'b0000_0101, 5'd1, 5'd0, 5'd7);
            tick();
            present(8'b0000_0100, 5'd7, 5'd0, 5'd8);
            tick();
            if (i == 10) begin
                n_checks++;
                if (bubble_count !== m_cnt) begin
                    n_fail++; $display("FAIL sat_midway got %h want %h", bubble_count, m_cnt);
                end
            end
        end
        n_checks++;
        if (bubble_count !== CNT_MAX) begin
            n_fail++; $display("FAIL sat_value got %h want %h", bubble_count, CNT_MAX);
        end
        present(8'b0000_0000, 5'd1, 5'd2, 5'd3);
        tick();
        ex_ready = 1'b0;
        present(8'b0000_0000, 5'd4, 5'd5, 5'd6);
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (ex_valid !== 1'b0 || bubble_count !== '0 ||
            {ex_instr, ex_pc, ex_op_a, ex_op_b, ex_store_data, ex_rd, ex_ctrl} !== '0) begin
            n_fail++; $display("FAIL async_reset got valid=%b cnt=%h instr=%h rd=%h want 0 0 0 0",
                               ex_valid, bubble_count, ex_instr, ex_rd);
        end
        model_reset();
        @(posedge clk); #1 rst_n = 1'b1;
        ex_ready = 1'b1;
        present(8'b0000_0000, 5'd1, 5'd2, 5'd11);
        tick();
        n_checks++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd11) begin
            n_fail++; $display("FAIL post_reset_handshake got valid=%b rd=%h want 1 0b", ex_valid, ex_rd);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            id_valid     = ($urandom_range(0, 3) != 0);
            id_instr     = $urandom; id_pc = $urandom; id_imm = $urandom;
            id_rs1_data  = $urandom; id_rs2_data = $urandom;
            id_rs1       = 5'($urandom_range(0, 3));
            id_rs2       = 5'($urandom_range(0, 3));
            id_rd        = 5'($urandom_range(0, 3));
            id_ctrl      = 8'($urandom);
            forward_a    = 2'($urandom); forward_b = 2'($urandom);
            exmem_result = $urandom; memwb_result = $urandom;
            ex_ready     = ($urandom_range(0, 3) != 0);
            flush        = ($urandom_range(0, 15) == 0);
            #1;
            n_checks++;
            if (id_ready !== model_ready()) begin
                n_fail++; $display("FAIL rnd_ready[%0d] got %b want %b", i, id_ready, model_ready());
            end
            tick();
            n_checks++;
            if (ex_valid !== m_valid || ex_rd !== m_rd || ex_ctrl !== m_ctrl || bubble_count !== m_cnt) begin
                n_fail++; $display("FAIL rnd_ctrl[%0d] got v=%b rd=%h ctrl=%h cnt=%h want %b %h %h %h",
                                   i, ex_valid, ex_rd, ex_ctrl, bubble_count, m_valid, m_rd, m_ctrl, m_cnt);
            end
            n_checks++;
            if (ex_instr !== m_instr || ex_pc !== m_pc || ex_op_a !== m_op_a ||
                ex_op_b !== m_op_b || ex_store_data !== m_store) begin
                n_fail++; $display("FAIL rnd_data[%0d] got %h %h %h %h %h want %h %h %h %h %h", i,
                                   ex_instr, ex_pc, ex_op_a, ex_op_b, ex_store_data,
                                   m_instr, m_pc, m_op_a, m_op_b, m_store);
            end
        end
        flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_forward_a();
        test_alu_src();
        test_load_use();
        test_no_hazard();
        test_stall_flush();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
